johnson_seq_ctrl: RTL
=====================

Name: johnson_seq_ctrl

Overview:
- Sequencing controller wrapped around a parameterised Johnson (twisted-ring) phase register.
- Starts, pauses, stops and drains the ring, and runs a programmed number of full revolutions in either direction.
- Decodes the current state to a one-hot phase vector.
- Detects illegal (non-Johnson) codes and recovers from them.
- Drives multi-phase enables for downstream datapath stages.

Parameters:
- W, 4, Johnson register width; sequence length 2*W states.
- CNT_W, 8, width of the revolution target and the revolution counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; honoured only in IDLE.
- stop  in  1  request orderly stop (drain to all-zero).
- pause  in  1  hold ring while high; honoured only in RUN.
- dir  in  1  0 = forward, 1 = reverse; latched at start.
- cycles  in  CNT_W  revolutions to run; 0 = run until stop; latched at start.
- load  in  1  IDLE only: q <= load_val (configuration/test).
- load_val  in  W  value for load.
- q  out  W  Johnson register.
- phase  out  2*W  one-hot decode of q by forward-sequence index.
- busy  out  1  high in RUN, PAUSE, DRAIN.
- done  out  1  one-cycle pulse on return to IDLE.
- rev_cnt  out  CNT_W  completed revolutions this run.
- err  out  1  sticky illegal-code flag.

Behaviour:
- Reset (async): state IDLE, q=0, rev_cnt=0, err=0, done=0, busy=0, dir/cycles latches 0.
- Forward step: q <= {~q[0], q[W-1:1]}.
  - W=4 sequence: 0000,1000,1100,1110,1111,0111,0011,0001,0000.
- Reverse step: q <= {q[W-2:0], ~q[W-1]}.
  - W=4 sequence: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Phase decode:
  - Index k: k=0 for all-zero; k=1..W for the top k bits set; k=W+1..2W-1 for the top k-W bits clear and the rest set.
  - phase[k]=1.
  - Illegal code: phase=0.
  - Combinational from q.
- Legal codes are exactly the 2*W Johnson patterns.
- FSM states: IDLE, RUN, PAUSE, DRAIN.
- IDLE:
  - start=1 and stop=0: latch dir and cycles, clear rev_cnt and err, go to RUN. q is unchanged at that edge.
  - start and stop both high: stay in IDLE.
  - load=1 with start=0: q <= load_val. No legality check in IDLE.
  - If start and load are both high, start wins and load is ignored.
- RUN:
  - q steps every edge with pause=0. The first step occurs on the edge after the start edge.
  - pause=1 and stop=0: go to PAUSE and hold q.
  - stop=1: go to DRAIN; stop beats pause.
  - A revolution completes on an edge where q steps from a nonzero code to 0000; rev_cnt increments on that edge.
  - If cycles≠0 and the incremented rev_cnt equals cycles: go to IDLE and pulse done on the next cycle.
  - If cycles=0: rev_cnt wraps modulo 2^CNT_W.
- PAUSE:
  - q holds.
  - pause=0: return to RUN; stepping resumes on the following edge.
  - stop=1: go to DRAIN.
- DRAIN:
  - Ignores pause.
  - Steps each edge in the latched direction until q==0, then goes to IDLE with a done pulse.
  - If q==0 on entry, go to IDLE on the next edge.
  - A revolution finishing during drain still increments rev_cnt.
- Illegal code detected in RUN or DRAIN:
  - Next edge forces q=0000 and sets err.
  - No rev_cnt increment.
  - State unchanged; DRAIN then completes immediately.
  - err clears only on reset or accepted start.
- Illegal code in PAUSE is held until resume.
- start, load, dir and cycles are ignored outside IDLE.
- busy is registered with state and is high in RUN, PAUSE and DRAIN.
- done is registered and high for exactly one cycle after the transition into IDLE.
- Reset mid-operation aborts immediately to reset values. No done pulse.

Test Plan:
- W=4, fwd, cycles=2:
  - start at edge 0 -> q follows 1000,1100,…,0000 twice (16 steps, edges 1–16).
  - rev_cnt 1 at edge 8 and 2 at edge 16.
  - IDLE and done=1 for one cycle after edge 16; busy low thereafter.
- dir=1, cycles=1 -> q=0001,0011,0111,1111,1110,1100,1000,0000.
  - phase walks 0x01→0x80→0x40…→0x02→0x01.
  - done once; rev_cnt=1.
- cycles=0, pause high for 3 cycles at q=1110 -> q holds 1110 for 3 cycles; next state 1111 one edge after pause drops.
- stop asserted at q=0111 with pause also high -> DRAIN: 0011,0001,0000; then IDLE, done pulse; rev_cnt incremented by 1.
- In IDLE, load_val=0101 then start fwd -> first RUN edge q=0000 and err=1; run continues from 0000.
  - Next start clears err.
- Mid-run rst at q=1100 -> q=0000, busy=0, done=0, rev_cnt=0 immediately.
  - start in the same cycle as stop in IDLE -> no run.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted-ring) sequencing controller.
// Runs the ring forward or in reverse for a programmed number of revolutions,
// with pause, orderly drain to all-zero, one-hot phase decode, and recovery
// from non-Johnson codes.
module johnson_seq_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic [CNT_W-1:0] cycles,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  output logic [W-1:0]     q,
  output logic [2*W-1:0]   phase,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rev_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One forward step of the ring: shift right, feed back inverted LSB.
  function automatic logic [W-1:0] step_fwd(input logic [W-1:0] v);
    return {~v[0], v[W-1:1]};
  endfunction

  // One reverse step of the ring: shift left, feed back inverted MSB.
  function automatic logic [W-1:0] step_rev(input logic [W-1:0] v);
    return {v[W-2:0], ~v[W-1]};
  endfunction

  // One-hot decode by forward-sequence index; all-zero for illegal codes.
  function automatic logic [2*W-1:0] decode(input logic [W-1:0] v);
    logic [2*W-1:0] hot;
    logic [W-1:0]   code;
    hot  = {(2*W){1'b0}};
    code = {W{1'b0}};
    for (int k = 0; k < 2*W; k++) begin
      if (v == code) begin
        hot[k] = 1'b1;
      end else begin
        hot[k] = 1'b0;
      end
      code = step_fwd(code);
    end
    return hot;
  endfunction

  state_t           state_r, state_s;
  logic [W-1:0]     q_r, q_s;
  logic [CNT_W-1:0] rev_r, rev_s;
  logic [CNT_W-1:0] cyc_r, cyc_s;
  logic             dir_r, dir_s;
  logic             err_r, err_s;
  logic             done_r, done_s;
  logic             busy_r, busy_s;

  logic [2*W-1:0]   phase_s;
  logic             legal_s;
  logic [W-1:0]     step_s;
  logic             wrap_s;
  logic [CNT_W-1:0] rev_inc_s;

  assign phase_s   = decode(q_r);
  assign legal_s   = |phase_s;
  assign step_s    = dir_r ? step_rev(q_r) : step_fwd(q_r);
  // A revolution closes when a nonzero code steps onto all-zero.
  assign wrap_s    = (q_r != {W{1'b0}}) && (step_s == {W{1'b0}});
  assign rev_inc_s = rev_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    rev_s   = rev_r;
    cyc_s   = cyc_r;
    dir_s   = dir_r;
    err_s   = err_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          dir_s   = dir;
          cyc_s   = cycles;
          rev_s   = {CNT_W{1'b0}};
          err_s   = 1'b0;
          state_s = RUN;
        end else if (!start && load) begin
          q_s = load_val;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!legal_s) begin
          // Recovery takes priority: park on all-zero, stay in RUN.
          q_s   = {W{1'b0}};
          err_s = 1'b1;
        end else if (stop) begin
          state_s = DRAIN;
        end else if (pause) begin
          state_s = PAUSE;
        end else begin
          q_s = step_s;
          if (wrap_s) begin
            rev_s = rev_inc_s;
            if ((cyc_r != {CNT_W{1'b0}}) && (rev_inc_s == cyc_r)) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = RUN;
            end
          end else begin
            rev_s = rev_r;
          end
        end
      end
      PAUSE: begin
        if (stop) begin
          state_s = DRAIN;
        end else if (!pause) begin
          state_s = RUN;
        end else begin
          state_s = PAUSE;
        end
      end
      DRAIN: begin
        if (!legal_s) begin
          q_s   = {W{1'b0}};
          err_s = 1'b1;
        end else if (q_r == {W{1'b0}}) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          q_s = step_s;
          if (wrap_s) begin
            // Stepping onto zero finishes the drain on the same edge.
            rev_s   = rev_inc_s;
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = DRAIN;
          end
        end
      end
      default: begin
        state_s = IDLE;
        q_s     = {W{1'b0}};
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= {W{1'b0}};
      rev_r   <= {CNT_W{1'b0}};
      cyc_r   <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      rev_r   <= rev_s;
      cyc_r   <= cyc_s;
      dir_r   <= dir_s;
      err_r   <= err_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign q       = q_r;
  assign phase   = phase_s;
  assign busy    = busy_r;
  assign done    = done_r;
  assign rev_cnt = rev_r;
  assign err     = err_r;

endmodule
